// File: rtl/calc_pkg.sv
// Shared command/response codes and port state encoding for the calc port scheduler.
package calc_pkg;

    localparam int CMD_NOP = 0;
    localparam int CMD_ADD = 1;
    localparam int CMD_SUB = 2;
    localparam int CMD_SHL = 5;
    localparam int CMD_SHR = 6;

    localparam logic [1:0] RESP_NONE    = 2'd0;
    localparam logic [1:0] RESP_OK      = 2'd1;
    localparam logic [1:0] RESP_ERR     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        PORT_IDLE,
        PORT_OP2,
        PORT_PEND,
        PORT_ISSUED,
        PORT_RESP
    } port_state_t;

    function automatic logic cmd_supported(int cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc_port_capture.sv
// One requester port: two-cycle request capture, ALU hand-off and timeout.
// CALC_SCHED_CMD_CHECK_EN: unsupported commands are answered with an error without reaching the ALU.
module calc_port_capture
    import calc_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int CMD_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:CMD_W-1]  cmd_i,
    input  logic [0:DATA_W-1] data_i,
    input  logic              grant_i,
    input  logic              done_i,
    input  logic [0:1]        alu_resp_i,
    input  logic [0:DATA_W-1] alu_data_i,
    output logic              pend_o,
    output logic [0:CMD_W-1]  cmd_o,
    output logic [0:DATA_W-1] op1_o,
    output logic [0:DATA_W-1] op2_o,
    output logic [0:1]        resp_o,
    output logic [0:DATA_W-1] data_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    port_state_t       state_q, state_d;
    logic [0:CMD_W-1]  cmd_q, cmd_d;
    logic [0:DATA_W-1] op1_q, op1_d;
    logic [0:DATA_W-1] op2_q, op2_d;
    logic [0:1]        resp_q, resp_d;
    logic [0:DATA_W-1] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ok;

`ifdef CALC_SCHED_CMD_CHECK_EN
    assign cmd_ok = cmd_supported(int'(cmd_q));
`else
    assign cmd_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PORT_IDLE;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            resp_q  <= RESP_NONE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            resp_q  <= resp_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        resp_d  = resp_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            PORT_IDLE: begin
                if (cmd_i != CMD_W'(CMD_NOP)) begin
                    cmd_d   = cmd_i;
                    op1_d   = data_i;
                    state_d = PORT_OP2;
                end
            end
            PORT_OP2: begin
                op2_d = data_i;
                if (cmd_ok) begin
                    state_d = PORT_PEND;
                end else begin
                    resp_d  = RESP_ERR;
                    data_d  = '0;
                    state_d = PORT_RESP;
                end
            end
            PORT_PEND: begin
                if (grant_i) begin
                    cnt_d   = '0;
                    state_d = PORT_ISSUED;
                end
            end
            PORT_ISSUED: begin
                // A result arriving on the expiry cycle still wins over the timeout.
                if (done_i) begin
                    resp_d  = alu_resp_i;
                    data_d  = alu_data_i;
                    state_d = PORT_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_d  = RESP_TIMEOUT;
                    data_d  = '0;
                    state_d = PORT_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PORT_RESP: state_d = PORT_IDLE;
            default:   state_d = PORT_IDLE;
        endcase
    end

    assign pend_o = (state_q == PORT_PEND);
    assign cmd_o  = cmd_q;
    assign op1_o  = op1_q;
    assign op2_o  = op2_q;
    assign resp_o = (state_q == PORT_RESP) ? resp_q : RESP_NONE;
    assign data_o = (state_q == PORT_RESP) ? data_q : '0;

endmodule

// File: rtl/calc_port_scheduler.sv
// Shares one calc ALU between NUM_PORTS two-cycle requesters: round-robin issue, tag-routed results.
// Optional build macro: CALC_SCHED_CMD_CHECK_EN (reject unsupported commands inside the ports).
module calc_port_scheduler
    import calc_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_W         = 32,
    parameter int CMD_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    input  logic [0:NUM_PORTS*CMD_W-1]  req_cmd_in,
    input  logic [0:NUM_PORTS*DATA_W-1] req_data_in,
    output logic [0:NUM_PORTS*DATA_W-1] out_data,
    output logic [0:NUM_PORTS*2-1]      out_resp,
    output logic                        alu_valid_out,
    input  logic                        alu_ready_in,
    output logic [0:CMD_W-1]            alu_cmd_out,
    output logic [0:DATA_W-1]           alu_op1_out,
    output logic [0:DATA_W-1]           alu_op2_out,
    output logic [0:1]                  alu_tag_out,
    input  logic                        alu_done_in,
    input  logic [0:1]                  alu_tag_in,
    input  logic [0:1]                  alu_resp_in,
    input  logic [0:DATA_W-1]           alu_data_in
);

    logic              pend_w [NUM_PORTS];
    logic [0:CMD_W-1]  cmd_w  [NUM_PORTS];
    logic [0:DATA_W-1] op1_w  [NUM_PORTS];
    logic [0:DATA_W-1] op2_w  [NUM_PORTS];
    logic [0:1]        resp_w [NUM_PORTS];
    logic [0:DATA_W-1] data_w [NUM_PORTS];

    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [1:0]        rr_q, rr_d;
    logic              valid_q, valid_d;
    logic [0:CMD_W-1]  cmd_q, cmd_d;
    logic [0:DATA_W-1] op1_q, op1_d;
    logic [0:DATA_W-1] op2_q, op2_d;
    logic [0:1]        tag_q, tag_d;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            calc_port_capture #(
                .DATA_W         (DATA_W),
                .CMD_W          (CMD_W),
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_port (
                .clk        (c_clk),
                .rst_n      (reset_n),
                .cmd_i      (req_cmd_in[gi*CMD_W +: CMD_W]),
                .data_i     (req_data_in[gi*DATA_W +: DATA_W]),
                .grant_i    (grant_valid && (grant_idx == 2'(gi))),
                .done_i     (alu_done_in && (alu_tag_in == 2'(gi))),
                .alu_resp_i (alu_resp_in),
                .alu_data_i (alu_data_in),
                .pend_o     (pend_w[gi]),
                .cmd_o      (cmd_w[gi]),
                .op1_o      (op1_w[gi]),
                .op2_o      (op2_w[gi]),
                .resp_o     (resp_w[gi]),
                .data_o     (data_w[gi])
            );
            assign out_resp[gi*2 +: 2]      = resp_w[gi];
            assign out_data[gi*DATA_W +: DATA_W] = data_w[gi];
        end
    endgenerate

    // Scan downwards so the pending port closest to rr_q is the last (winning) assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (pend_w[(int'(rr_q) + k) % NUM_PORTS]) begin
                grant_valid = 1'b1;
                grant_idx   = 2'((int'(rr_q) + k) % NUM_PORTS);
            end
        end
        grant_valid = grant_valid && alu_ready_in;

        rr_d    = rr_q;
        valid_d = grant_valid;
        cmd_d   = '0;
        op1_d   = '0;
        op2_d   = '0;
        tag_d   = '0;
        if (grant_valid) begin
            rr_d  = 2'((int'(grant_idx) + 1) % NUM_PORTS);
            cmd_d = cmd_w[grant_idx];
            op1_d = op1_w[grant_idx];
            op2_d = op2_w[grant_idx];
            tag_d = grant_idx;
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q    <= '0;
            valid_q <= 1'b0;
            cmd_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            tag_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            tag_q   <= tag_d;
        end
    end

    assign alu_valid_out = valid_q;
    assign alu_cmd_out   = cmd_q;
    assign alu_op1_out   = op1_q;
    assign alu_op2_out   = op2_q;
    assign alu_tag_out   = tag_q;

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Directed bench for calc_port_scheduler with a behavioural ALU (per-request latency, ignorable tags).
module tb_calc_port_scheduler;

    logic         c_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [0:15]  req_cmd_in = '0;
    logic [0:127] req_data_in = '0;
    logic [0:127] out_data;
    logic [0:7]   out_resp;
    logic         alu_valid_out;
    logic         alu_ready_in = 1'b1;
    logic [0:3]   alu_cmd_out;
    logic [0:31]  alu_op1_out;
    logic [0:31]  alu_op2_out;
    logic [0:1]   alu_tag_out;
    logic         alu_done_in;
    logic [0:1]   alu_tag_in;
    logic [0:1]   alu_resp_in;
    logic [0:31]  alu_data_in;

    calc_port_scheduler dut (
        .c_clk         (c_clk),
        .reset_n       (reset_n),
        .req_cmd_in    (req_cmd_in),
        .req_data_in   (req_data_in),
        .out_data      (out_data),
        .out_resp      (out_resp),
        .alu_valid_out (alu_valid_out),
        .alu_ready_in  (alu_ready_in),
        .alu_cmd_out   (alu_cmd_out),
        .alu_op1_out   (alu_op1_out),
        .alu_op2_out   (alu_op2_out),
        .alu_tag_out   (alu_tag_out),
        .alu_done_in   (alu_done_in),
        .alu_tag_in    (alu_tag_in),
        .alu_resp_in   (alu_resp_in),
        .alu_data_in   (alu_data_in)
    );

    always #5 c_clk = ~c_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int idle_bad = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural ALU ----------------
    typedef struct {int due; logic [1:0] tag; logic [1:0] resp; logic [31:0] data;} alu_ent_t;
    alu_ent_t    alu_q[$];
    int          alu_lat = 1;
    logic [3:0]  ignore_tag = '0;
    int          inj_cnt = 0;
    int          inj_seen = 0;
    logic [1:0]  inj_tag = '0;
    logic [31:0] inj_data = '0;

    function automatic logic [33:0] alu_eval(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            4'd1:    return {2'd1, a + b};
            4'd2:    return {2'd1, a - b};
            4'd5:    return {2'd1, a << b[4:0]};
            4'd6:    return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    initial begin
        alu_ent_t    e;
        logic [33:0] r;
        alu_done_in = 1'b0;
        alu_tag_in  = '0;
        alu_resp_in = '0;
        alu_data_in = '0;
        forever begin
            @(posedge c_clk);
            cyc++;
            if (alu_valid_out && !ignore_tag[alu_tag_out]) begin
                r = alu_eval(alu_cmd_out, alu_op1_out, alu_op2_out);
                alu_q.push_back('{cyc + alu_lat - 1, alu_tag_out, r[33:32], r[31:0]});
            end
            #1;
            if (alu_q.size() > 0 && alu_q[0].due <= cyc) begin
                e = alu_q.pop_front();
                alu_done_in = 1'b1;
                alu_tag_in  = e.tag;
                alu_resp_in = e.resp;
                alu_data_in = e.data;
            end else if (inj_cnt != inj_seen) begin
                inj_seen++;
                alu_done_in = 1'b1;
                alu_tag_in  = inj_tag;
                alu_resp_in = 2'd1;
                alu_data_in = inj_data;
            end else begin
                alu_done_in = 1'b0;
                alu_tag_in  = '0;
                alu_resp_in = '0;
                alu_data_in = '0;
            end
        end
    end

    // ---------------- monitor (negedge sampling) ----------------
    typedef struct {int cyc; logic [1:0] tag; logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2;} iss_t;
    typedef struct {int cyc; int port; logic [1:0] resp; logic [31:0] data;} rsp_t;
    iss_t iss_q[$];
    rsp_t rsp_q[$];

    always @(negedge c_clk) begin
        logic [1:0]  r;
        logic [31:0] d;
        if (alu_valid_out)
            iss_q.push_back('{cyc, alu_tag_out, alu_cmd_out, alu_op1_out, alu_op2_out});
        else if (alu_cmd_out != 0 || alu_op1_out != 0 || alu_op2_out != 0 || alu_tag_out != 0)
            idle_bad++;
        for (int p = 0; p < 4; p++) begin
            r = out_resp[p*2 +: 2];
            d = out_data[p*32 +: 32];
            if (r != 2'd0) rsp_q.push_back('{cyc, p, r, d});
            else if (d != 32'd0) idle_bad++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_port(int p, logic [3:0] c, logic [31:0] d);
        req_cmd_in[p*4 +: 4]    = c;
        req_data_in[p*32 +: 32] = d;
    endtask

    task automatic send(int p, logic [3:0] c, logic [31:0] op1, logic [31:0] op2, output int e0);
        @(negedge c_clk);
        e0 = cyc + 1;
        set_port(p, c, op1);
        @(negedge c_clk);
        set_port(p, 4'd0, op2);
        @(negedge c_clk);
        set_port(p, 4'd0, 32'd0);
    endtask

    task automatic clear_q();
        iss_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(negedge c_clk);
    endtask

    typedef struct {
        int port; logic [3:0] cmd; logic [31:0] op1; logic [31:0] op2; int lat;
        logic [1:0] exp_resp; logic [31:0] exp_data; int exp_rsp_lat;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        logic [31:0] exp_d[4];

        vecs[0] = '{0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 1, 2'd1, 32'h2000_0000, 4};
        vecs[1] = '{1, 4'd2, 32'd10,        32'd3,         1, 2'd1, 32'd7,         4};
        vecs[2] = '{2, 4'd5, 32'd1,         32'd4,         3, 2'd1, 32'd16,        6};
        vecs[3] = '{0, 4'd1, 32'hFFFF_FFFF, 32'd1,         1, 2'd1, 32'd0,         4};
        vecs[4] = '{2, 4'd6, 32'h8000_0000, 32'd31,        2, 2'd1, 32'd1,         5};
        vecs[5] = '{3, 4'd2, 32'h0000_0100, 32'd1,         1, 2'd1, 32'h0000_00FF, 4};
        exp_d = '{32'h10, 32'h21, 32'h32, 32'h43};

        // Reset state
        #22;
        chk("reset_valid", alu_valid_out, 0);
        chk("reset_resp", out_resp, 0);
        chk("reset_data", out_data, 0);
        chk("reset_issue_fields", {alu_cmd_out, alu_tag_out, alu_op1_out}, 0);
        @(negedge c_clk);
        reset_n = 1'b1;
        wait_cyc(2);

        // Table-driven single requests
        for (int i = 0; i < 6; i++) begin
            clear_q();
            alu_lat = vecs[i].lat;
            send(vecs[i].port, vecs[i].cmd, vecs[i].op1, vecs[i].op2, e0);
            wait_cyc(vecs[i].lat + 4);
            chk($sformatf("v%0d_issue_count", i), iss_q.size(), 1);
            if (iss_q.size() > 0) begin
                chk($sformatf("v%0d_tag", i), iss_q[0].tag, vecs[i].port);
                chk($sformatf("v%0d_cmd", i), iss_q[0].cmd, vecs[i].cmd);
                chk($sformatf("v%0d_op1", i), iss_q[0].op1, vecs[i].op1);
                chk($sformatf("v%0d_op2", i), iss_q[0].op2, vecs[i].op2);
                chk($sformatf("v%0d_issue_lat", i), iss_q[0].cyc - e0, 2);
            end
            chk($sformatf("v%0d_resp_count", i), rsp_q.size(), 1);
            if (rsp_q.size() > 0) begin
                chk($sformatf("v%0d_resp_port", i), rsp_q[0].port, vecs[i].port);
                chk($sformatf("v%0d_resp", i), rsp_q[0].resp, vecs[i].exp_resp);
                chk($sformatf("v%0d_data", i), rsp_q[0].data, vecs[i].exp_data);
                chk($sformatf("v%0d_resp_lat", i), rsp_q[0].cyc - e0, vecs[i].exp_rsp_lat);
                $display("vec %0d: port %0d cmd %0d -> resp %0d data 0x%08h", i, vecs[i].port,
                         vecs[i].cmd, rsp_q[0].resp, rsp_q[0].data);
            end
        end
        alu_lat = 1;

        // All four ports at once, twice: order 0..3 both rounds
        for (int rnd = 0; rnd < 2; rnd++) begin
            clear_q();
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) set_port(p, 4'd1, 32'(16 * (p + 1)));
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'(p));
            @(negedge c_clk);
            for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd0);
            wait_cyc(10);
            chk($sformatf("rr%0d_issue_count", rnd), iss_q.size(), 4);
            chk($sformatf("rr%0d_resp_count", rnd), rsp_q.size(), 4);
            for (int k = 0; k < 4; k++) begin
                if (iss_q.size() > k) begin
                    chk($sformatf("rr%0d_tag%0d", rnd, k), iss_q[k].tag, k);
                    chk($sformatf("rr%0d_cyc%0d", rnd, k), iss_q[k].cyc - iss_q[0].cyc, k);
                end
                if (rsp_q.size() > k) begin
                    chk($sformatf("rr%0d_rport%0d", rnd, k), rsp_q[k].port, k);
                    chk($sformatf("rr%0d_rdata%0d", rnd, k), rsp_q[k].data, exp_d[k]);
                end
            end
            $display("round %0d: %0d issues, %0d responses", rnd, iss_q.size(), rsp_q.size());
        end

        // ALU not ready with ports 1 and 3 pending
        clear_q();
        alu_ready_in = 1'b0;
        @(negedge c_clk);
        set_port(1, 4'd1, 32'd1);
        set_port(3, 4'd1, 32'd3);
        @(negedge c_clk);
        set_port(1, 4'd0, 32'd1);
        set_port(3, 4'd0, 32'd3);
        @(negedge c_clk);
        set_port(1, 4'd0, 32'd0);
        set_port(3, 4'd0, 32'd0);
        wait_cyc(8);
        chk("stall_no_issue", iss_q.size(), 0);
        alu_ready_in = 1'b1;
        wait_cyc(8);
        chk("stall_issue_count", iss_q.size(), 2);
        if (iss_q.size() == 2) begin
            chk("stall_first_tag", iss_q[0].tag, 1);
            chk("stall_second_tag", iss_q[1].tag, 3);
        end
        chk("stall_resp_count", rsp_q.size(), 2);
        $display("stall release: %0d issues", iss_q.size());

        // Unsupported command 3 on port 2
        clear_q();
        send(2, 4'd3, 32'd5, 32'd6, e0);
        wait_cyc(6);
`ifdef CALC_SCHED_CMD_CHECK_EN
        chk("badcmd_no_issue", iss_q.size(), 0);
        if (rsp_q.size() > 0) chk("badcmd_resp_lat", rsp_q[0].cyc - e0, 1);
`else
        chk("badcmd_issue_count", iss_q.size(), 1);
        if (iss_q.size() > 0) begin
            chk("badcmd_cmd", iss_q[0].cmd, 3);
            chk("badcmd_tag", iss_q[0].tag, 2);
        end
`endif
        chk("badcmd_resp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            chk("badcmd_resp", rsp_q[0].resp, 2);
            chk("badcmd_data", rsp_q[0].data, 0);
        end
        $display("cmd 3 on port 2: %0d issues, %0d responses", iss_q.size(), rsp_q.size());

        // Reset while port 0 is issued
        ignore_tag = 4'b0001;
        send(0, 4'd1, 32'd7, 32'd8, e0);
        @(posedge c_clk);
        #2;
        chk("prereset_valid", alu_valid_out, 1);
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", alu_valid_out, 0);
        chk("midreset_fields", {alu_cmd_out, alu_tag_out, alu_op1_out, alu_op2_out}, 0);
        chk("midreset_resp", out_resp, 0);
        wait_cyc(2);
        reset_n = 1'b1;
        ignore_tag = 4'b0000;
        clear_q();
        inj_tag  = 2'd0;
        inj_data = 32'hDEAD_BEEF;
        inj_cnt++;
        wait_cyc(5);
        chk("postreset_stale_done", rsp_q.size(), 0);
        send(0, 4'd1, 32'd2, 32'd3, e0);
        wait_cyc(5);
        chk("postreset_resp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) chk("postreset_data", rsp_q[0].data, 5);
        $display("reset recovery: %0d responses", rsp_q.size());

        // Command arriving on the same edge as its port's done is dropped
        clear_q();
        send(0, 4'd1, 32'd1, 32'd1, e0);
        wait_cyc(2);
        set_port(0, 4'd1, 32'd7);
        @(negedge c_clk);
        set_port(0, 4'd0, 32'd7);
        @(negedge c_clk);
        set_port(0, 4'd0, 32'd0);
        wait_cyc(6);
        chk("donecmd_issue_count", iss_q.size(), 1);
        chk("donecmd_resp_count", rsp_q.size(), 1);
        if (rsp_q.size() > 0) chk("donecmd_data", rsp_q[0].data, 2);
        $display("done+cmd collision: %0d issues", iss_q.size());

        // Timeout on port 1, with a dropped command while issued and a late done
        clear_q();
        ignore_tag = 4'b0010;
        send(1, 4'd1, 32'd4, 32'd4, e0);
        wait_cyc(5);
        send(1, 4'd2, 32'd9, 32'd9, e0);
        wait_cyc(70);
        chk("timeout_issue_count", iss_q.size(), 1);
        chk("timeout_resp_count", rsp_q.size(), 1);
        if (iss_q.size() > 0 && rsp_q.size() > 0) begin
            chk("timeout_tag", iss_q[0].tag, 1);
            chk("timeout_resp", rsp_q[0].resp, 3);
            chk("timeout_data", rsp_q[0].data, 0);
            chk("timeout_cycles", rsp_q[0].cyc - iss_q[0].cyc, 64);
        end
        clear_q();
        inj_tag  = 2'd1;
        inj_data = 32'h1234_5678;
        inj_cnt++;
        wait_cyc(5);
        chk("timeout_late_done", rsp_q.size(), 0);
        ignore_tag = 4'b0000;
        $display("timeout on port 1 handled");

        chk("idle_outputs_zero", idle_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
